// File: rtl/iq_mixer_integrator.sv
// I/Q mixer with integrate-and-dump decimation: one baseband I/Q pair per DECIM valid samples.
// Define IQ_MAG_EN to add a registered magnitude-estimate stage (one extra cycle of latency).
module iq_mixer_integrator #(
    parameter int DECIM = 64,
    parameter int ACC_W = 38
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    clear_in,
    input  logic                    sample_valid_in,
    input  logic signed [15:0]      sample_in,
    input  logic signed [15:0]      lo_i_in,
    input  logic signed [15:0]      lo_q_in,
    output logic signed [ACC_W-1:0] i_out,
    output logic signed [ACC_W-1:0] q_out,
    output logic        [ACC_W-1:0] mag_out,
    output logic                    valid_out
);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    if (DECIM < 2) begin : g_bad_decim
        $error("iq_mixer_integrator: DECIM must be >= 2");
    end
    if (ACC_W < 32 + $clog2(DECIM)) begin : g_bad_accw
        $error("iq_mixer_integrator: ACC_W must be >= 32 + clog2(DECIM)");
    end

    logic signed [15:0]      s1Sample_q, s1LoI_q, s1LoQ_q;
    logic                    s1Valid_q;
    logic signed [31:0]      s2ProdI_q, s2ProdQ_q;
    logic signed [31:0]      prodI_d, prodQ_d;
    logic                    s2Valid_q;
    logic signed [ACC_W-1:0] accI_q, accQ_q, accI_d, accQ_d;
    logic signed [ACC_W-1:0] sumI, sumQ;
    logic        [CNT_W-1:0] count_q, count_d;
    logic signed [ACC_W-1:0] s3I_q, s3Q_q, s3I_d, s3Q_d;
    logic                    s3Valid_q, s3Valid_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1Sample_q <= '0;
            s1LoI_q    <= '0;
            s1LoQ_q    <= '0;
            s1Valid_q  <= 1'b0;
        end else begin
            s1Valid_q <= sample_valid_in & ~clear_in;
            if (sample_valid_in) begin
                s1Sample_q <= sample_in;
                s1LoI_q    <= lo_i_in;
                s1LoQ_q    <= lo_q_in;
            end
        end
    end

    assign prodI_d = 32'(s1Sample_q) * 32'(s1LoI_q);
    assign prodQ_d = 32'(s1Sample_q) * 32'(s1LoQ_q);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2ProdI_q <= '0;
            s2ProdQ_q <= '0;
            s2Valid_q <= 1'b0;
        end else begin
            s2Valid_q <= s1Valid_q & ~clear_in;
            if (s1Valid_q) begin
                s2ProdI_q <= prodI_d;
                s2ProdQ_q <= prodQ_d;
            end
        end
    end

    assign sumI = accI_q + ACC_W'(s2ProdI_q);
    assign sumQ = accQ_q + ACC_W'(s2ProdQ_q);

    // Bubbles leave the window untouched; the DECIM-th product dumps and restarts empty.
    always_comb begin
        accI_d    = accI_q;
        accQ_d    = accQ_q;
        count_d   = count_q;
        s3I_d     = s3I_q;
        s3Q_d     = s3Q_q;
        s3Valid_d = 1'b0;
        if (clear_in) begin
            accI_d  = '0;
            accQ_d  = '0;
            count_d = '0;
        end else if (s2Valid_q) begin
            if (count_q == LAST) begin
                s3I_d     = sumI;
                s3Q_d     = sumQ;
                s3Valid_d = 1'b1;
                accI_d    = '0;
                accQ_d    = '0;
                count_d   = '0;
            end else begin
                accI_d  = sumI;
                accQ_d  = sumQ;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            accI_q    <= '0;
            accQ_q    <= '0;
            count_q   <= '0;
            s3I_q     <= '0;
            s3Q_q     <= '0;
            s3Valid_q <= 1'b0;
        end else begin
            accI_q    <= accI_d;
            accQ_q    <= accQ_d;
            count_q   <= count_d;
            s3I_q     <= s3I_d;
            s3Q_q     <= s3Q_d;
            s3Valid_q <= s3Valid_d;
        end
    end

`ifdef IQ_MAG_EN
    logic [ACC_W-1:0] absI, absQ, magD;

    // The most negative value negates to itself, which read unsigned is exactly 2^(ACC_W-1).
    assign absI = s3I_q[ACC_W-1] ? $unsigned(-s3I_q) : $unsigned(s3I_q);
    assign absQ = s3Q_q[ACC_W-1] ? $unsigned(-s3Q_q) : $unsigned(s3Q_q);
    assign magD = (absI >= absQ) ? absI + (absQ >> 2) : absQ + (absI >> 2);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            i_out     <= '0;
            q_out     <= '0;
            mag_out   <= '0;
            valid_out <= 1'b0;
        end else if (clear_in) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= s3Valid_q;
            if (s3Valid_q) begin
                i_out   <= s3I_q;
                q_out   <= s3Q_q;
                mag_out <= magD;
            end
        end
    end
`else
    assign i_out     = s3I_q;
    assign q_out     = s3Q_q;
    assign mag_out   = '0;
    assign valid_out = s3Valid_q;
`endif

endmodule

// File: tb/tb_iq_mixer_integrator.sv
// Self-checking bench for iq_mixer_integrator: directed windows plus randomized traffic
// checked every cycle against a window-sum model built from queues of products and dumps.
module tb_iq_mixer_integrator;
    localparam int DECIM = 64;
    localparam int ACC_W = 38;
`ifdef IQ_MAG_EN
    localparam int     MAG_LAT = 1;
    localparam longint MAG_T1  = 64'd136000000;
    localparam longint MAG_T2  = 64'd85899345920;
`else
    localparam int     MAG_LAT = 0;
    localparam longint MAG_T1  = 64'd0;
    localparam longint MAG_T2  = 64'd0;
`endif

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    clear_in;
    logic                    sample_valid_in;
    logic signed [15:0]      sample_in;
    logic signed [15:0]      lo_i_in;
    logic signed [15:0]      lo_q_in;
    logic signed [ACC_W-1:0] i_out;
    logic signed [ACC_W-1:0] q_out;
    logic        [ACC_W-1:0] mag_out;
    logic                    valid_out;

    typedef struct { int arrival; longint pi; longint pq; } prod_t;
    typedef struct { int cyc; longint i; longint q; } dump_t;

    prod_t  pendQ[$];
    dump_t  expQ[$];
    int     edgeCnt  = 0;
    int     nChecks  = 0;
    int     nPass    = 0;
    int     pulseCnt = 0;
    longint lastI    = 0;
    longint lastQ    = 0;
    longint lastMag  = 0;

    iq_mixer_integrator #(.DECIM(DECIM), .ACC_W(ACC_W)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .clear_in        (clear_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .lo_i_in         (lo_i_in),
        .lo_q_in         (lo_q_in),
        .i_out           (i_out),
        .q_out           (q_out),
        .mag_out         (mag_out),
        .valid_out       (valid_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic longint magOf(longint i, longint q);
        longint ai = (i < 0) ? -i : i;
        longint aq = (q < 0) ? -q : q;
        longint mx = (ai >= aq) ? ai : aq;
        longint mn = (ai >= aq) ? aq : ai;
        return (MAG_LAT == 1) ? mx + (mn >> 2) : 64'd0;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input int s, input int li,
                                 input int lq, input bit clr);
        rst_in          = rst;
        sample_valid_in = v;
        sample_in       = 16'(s);
        lo_i_in         = 16'(li);
        lo_q_in         = 16'(lq);
        clear_in        = clr;
        @(posedge clk_in);
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic runWindow(input int s, input int li, input int lq, input int nValid,
                             input int gap);
        repeat (nValid) begin
            applyStimulus(1'b1, 1'b1, s, li, lq, 1'b0);
            repeat (gap) applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0);
        end
    endtask

    // Model: each accepted sample's products reach the integrator two edges later;
    // every DECIM-th arrival closes a window and schedules a dump.
    initial begin
        prod_t p;
        longint sumI, sumQ;
        int cnt;
        sumI = 0; sumQ = 0; cnt = 0;
        forever begin
            @(posedge clk_in);
            edgeCnt++;
            if (!rst_in || clear_in) begin
                pendQ.delete();
                expQ.delete();
                sumI = 0; sumQ = 0; cnt = 0;
            end else begin
                while (pendQ.size() > 0 && pendQ[0].arrival == edgeCnt) begin
                    p = pendQ.pop_front();
                    sumI += p.pi;
                    sumQ += p.pq;
                    cnt++;
                    if (cnt == DECIM) begin
                        expQ.push_back('{edgeCnt + MAG_LAT, sumI, sumQ});
                        sumI = 0; sumQ = 0; cnt = 0;
                    end
                end
                if (sample_valid_in)
                    pendQ.push_back('{edgeCnt + 2,
                                      longint'(sample_in) * longint'(lo_i_in),
                                      longint'(sample_in) * longint'(lo_q_in)});
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        dump_t d;
        bit expV;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                checkOutput("rst_valid", longint'(valid_out), 0);
                checkOutput("rst_i", i_out, 0);
                checkOutput("rst_q", q_out, 0);
                checkOutput("rst_mag", mag_out, 0);
                lastI = 0; lastQ = 0; lastMag = 0;
            end else begin
                expV = 1'b0;
                if (expQ.size() > 0 && expQ[0].cyc == edgeCnt) begin
                    d       = expQ.pop_front();
                    expV    = 1'b1;
                    lastI   = d.i;
                    lastQ   = d.q;
                    lastMag = magOf(d.i, d.q);
                end
                if (valid_out) pulseCnt++;
                checkOutput("valid", longint'(valid_out), longint'(expV));
                checkOutput("i_out", i_out, lastI);
                checkOutput("q_out", q_out, lastQ);
                checkOutput("mag_out", mag_out, lastMag);
            end
        end
    end

    initial begin
        int p0;
        int duty;
        bit rs, v, clr;
        rst_in = 1'b1; clear_in = 1'b0; sample_valid_in = 1'b0;
        sample_in = '0; lo_i_in = '0; lo_q_in = '0;
        #3 rst_in = 1'b0;
        @(posedge clk_in); #3;
        @(posedge clk_in); #3;
        checkOutput("reset_i", i_out, 0);
        checkOutput("reset_q", q_out, 0);
        checkOutput("reset_mag", mag_out, 0);
        checkOutput("reset_valid", longint'(valid_out), 0);
        idle(3);

        $display("[TB] test 1: continuous window");
        p0 = pulseCnt;
        runWindow(1000, 2000, -500, 64, 0);
        idle(4);
        checkOutput("t1_pulses", pulseCnt - p0, 1);
        checkOutput("t1_i", i_out, 128000000);
        checkOutput("t1_q", q_out, -32000000);
        checkOutput("t1_mag", mag_out, MAG_T1);

        $display("[TB] test 2: full-scale negative");
        p0 = pulseCnt;
        runWindow(-32768, -32768, -32768, 64, 0);
        idle(4);
        checkOutput("t2_pulses", pulseCnt - p0, 1);
        checkOutput("t2_i", i_out, 64'd68719476736);
        checkOutput("t2_q", q_out, 64'd68719476736);
        checkOutput("t2_mag", mag_out, MAG_T2);

        $display("[TB] test 3: valid 1-in-4");
        p0 = pulseCnt;
        runWindow(1000, 2000, -500, 64, 3);
        idle(4);
        checkOutput("t3_pulses", pulseCnt - p0, 1);
        checkOutput("t3_i", i_out, 128000000);
        checkOutput("t3_q", q_out, -32000000);

        $display("[TB] test 4: clear mid-window");
        p0 = pulseCnt;
        runWindow(1000, 2000, -500, 30, 0);
        applyStimulus(1'b1, 1'b1, 1000, 2000, -500, 1'b1);
        runWindow(1000, 2000, -500, 64, 0);
        idle(4);
        checkOutput("t4_pulses", pulseCnt - p0, 1);
        checkOutput("t4_i", i_out, 128000000);
        checkOutput("t4_q", q_out, -32000000);

        $display("[TB] test 5: reset mid-window");
        runWindow(7, 11, -13, 40, 0);
        rst_in = 1'b0;
        #1;
        checkOutput("t5_rst_i", i_out, 0);
        checkOutput("t5_rst_q", q_out, 0);
        checkOutput("t5_rst_mag", mag_out, 0);
        checkOutput("t5_rst_valid", longint'(valid_out), 0);
        @(posedge clk_in); #3;
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0);
        p0 = pulseCnt;
        runWindow(1000, 2000, -500, 64, 0);
        idle(4);
        checkOutput("t5_pulses", pulseCnt - p0, 1);
        checkOutput("t5_i", i_out, 128000000);
        checkOutput("t5_q", q_out, -32000000);

        $display("[TB] random traffic");
        duty = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) duty = int'($urandom_range(100, 20));
            rs  = ($urandom_range(999) != 0);
            v   = ($urandom_range(99) < duty);
            clr = ($urandom_range(299) == 0);
            applyStimulus(rs, v, int'($urandom_range(65535)), int'($urandom_range(65535)),
                          int'($urandom_range(65535)), clr);
        end
        idle(6);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
